// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional ANDI support enabled with `define ANDI_SUPPORT_EN.
//
// state  | meaning
// -------+-----------------------------------------------
// S_RST  | held in reset, all outputs idle
// FETCH  | read instruction, load IR, PC <= PC+4
// DECODE | register read, branch target precompute, dispatch
// MEMADR | effective address = A + signext(imm)
// MEMRD  | data memory read at ALUOut
// MEMWB  | write MDR into rt
// MEMWR  | data memory write at ALUOut
// EXEC   | R-type ALU operation on A, B
// RWB    | write ALUOut into rd
// BEQ    | compare A, B; branch to ALUOut if zero
// JMP    | PC <= jump target
// IMMEX  | A + signext(imm)
// IMMWB  | write ALUOut into rt
// ANDIEX | A & signext(imm) (ANDI_SUPPORT_EN only)
module multicycle_control #(
   parameter logic [5:0] OPC_RTYPE = 6'd0,
   parameter logic [5:0] OPC_J     = 6'd2,
   parameter logic [5:0] OPC_BEQ   = 6'd4,
   parameter logic [5:0] OPC_ADDI  = 6'd8,
   parameter logic [5:0] OPC_ANDI  = 6'd12,
   parameter logic [5:0] OPC_LW    = 6'd35,
   parameter logic [5:0] OPC_SW    = 6'd43
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsource,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal_op
);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BEQ    = 4'd9,
      S_JMP    = 4'd10,
      S_IMMEX  = 4'd11,
      S_IMMWB  = 4'd12,
      S_ANDIEX = 4'd13
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] opc_q, opc_d;
   logic       illegal_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RST;
         opc_q   <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      opc_d     = opc_q;
      illegal_d = 1'b0;
      case (state_q)
         S_RST:    state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            // Opcode captured here so later states never depend on the live IR field.
            opc_d = opcode;
            case (opcode)
               OPC_LW,
               OPC_SW:    state_d = S_MEMADR;
               OPC_RTYPE: state_d = S_EXEC;
               OPC_BEQ:   state_d = S_BEQ;
               OPC_J:     state_d = S_JMP;
               OPC_ADDI:  state_d = S_IMMEX;
`ifdef ANDI_SUPPORT_EN
               OPC_ANDI:  state_d = S_ANDIEX;
`else
               OPC_ANDI: begin
                  illegal_d = 1'b1;
                  state_d   = S_FETCH;
               end
`endif
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_FETCH;
               end
            endcase
         end
         S_MEMADR: state_d = (opc_q == OPC_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = S_FETCH;
         S_EXEC:   state_d = S_RWB;
         S_RWB:    state_d = S_FETCH;
         S_BEQ:    state_d = S_FETCH;
         S_JMP:    state_d = S_FETCH;
         S_IMMEX:  state_d = S_IMMWB;
         S_IMMWB:  state_d = S_FETCH;
`ifdef ANDI_SUPPORT_EN
         S_ANDIEX: state_d = S_IMMWB;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      aluop       = 2'b00;
      pcsource    = 2'b00;
      instr_done  = 1'b0;
      case (state_q)
         S_FETCH: begin
            memread = 1'b1;
            irwrite = 1'b1;
            pcwrite = 1'b1;
            alusrcb = 2'b01;
         end
         S_DECODE: alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite   = 1'b1;
            memtoreg   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            memwrite   = 1'b1;
            iord       = 1'b1;
            instr_done = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         S_RWB: begin
            regwrite   = 1'b1;
            regdst     = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQ: begin
            alusrca     = 1'b1;
            aluop       = 2'b01;
            pcwritecond = 1'b1;
            pcsource    = 2'b01;
            instr_done  = 1'b1;
         end
         S_JMP: begin
            pcwrite    = 1'b1;
            pcsource   = 2'b10;
            instr_done = 1'b1;
         end
         S_IMMEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_IMMWB: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
`ifdef ANDI_SUPPORT_EN
         S_ANDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = 2'b11;
         end
`endif
         default: ;
      endcase
   end

   assign state      = state_q;
   assign illegal_op = illegal_d;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks every instruction class and checks
// state code plus the full packed output vector each cycle.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
   logic       memtoreg, regdst, regwrite, alusrca;
   logic [1:0] alusrcb, aluop, pcsource;
   logic [3:0] state;
   logic       instr_done, illegal_op;

   int n_assert = 0;
   int n_fail   = 0;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
      .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
      .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
      .pcsource(pcsource), .state(state), .instr_done(instr_done),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   // Vector order: pcwrite pcwritecond iord memread memwrite irwrite memtoreg regdst
   // regwrite alusrca | alusrcb | aluop | pcsource | instr_done | illegal_op
   localparam logic [17:0] E_ZERO   = 18'b0;
   localparam logic [17:0] E_FETCH  = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] E_DEC    = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] E_DECILL = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
   localparam logic [17:0] E_MEMADR = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] E_MEMRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] E_MEMWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [17:0] E_MEMWR  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [17:0] E_EXEC   = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] E_RWB    = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [17:0] E_BEQ    = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
   localparam logic [17:0] E_JMP    = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
   localparam logic [17:0] E_IMMEX  = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
   localparam logic [17:0] E_IMMWB  = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
   localparam logic [17:0] E_ANDIEX = {10'b0000000001, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0};

   function automatic logic [17:0] outs();
      return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
              regwrite, alusrca, alusrcb, aluop, pcsource, instr_done, illegal_op};
   endfunction

   task automatic chk(input string tag, input logic [3:0] exp_st, input logic [17:0] exp_v);
      logic [17:0] got;
      got = outs();
      n_assert++;
      assert (state === exp_st) else begin
         n_fail++;
         $error("FAIL %s state: observed %0d expected %0d", tag, state, exp_st);
      end
      n_assert++;
      assert (got === exp_v) else begin
         n_fail++;
         $error("FAIL %s outputs: observed %b expected %b", tag, got, exp_v);
      end
   endtask

   task automatic step(input string tag, input logic [3:0] exp_st, input logic [17:0] exp_v);
      @(negedge clk);
      chk(tag, exp_st, exp_v);
   endtask

   initial begin
      reset  = 1'b1;
      opcode = 6'd0;
      repeat (3) @(negedge clk);
      chk("in_reset", 4'd0, E_ZERO);
      reset = 1'b0;
      #1 chk("post_release", 4'd0, E_ZERO);
      step("first_fetch", 4'd1, E_FETCH);

      // LW; live opcode changed in MEMADR must not redirect to MEMWR
      opcode = 6'd35;
      step("lw_dec", 4'd2, E_DEC);
      step("lw_memadr", 4'd3, E_MEMADR);
      opcode = 6'd43;
      step("lw_memrd", 4'd4, E_MEMRD);
      step("lw_memwb", 4'd5, E_MEMWB);
      step("lw_fetch", 4'd1, E_FETCH);

      // SW; live opcode changed in MEMADR must not redirect to MEMRD
      step("sw_dec", 4'd2, E_DEC);
      step("sw_memadr", 4'd3, E_MEMADR);
      opcode = 6'd35;
      step("sw_memwr", 4'd6, E_MEMWR);
      step("sw_fetch", 4'd1, E_FETCH);

      opcode = 6'd0;
      step("r_dec", 4'd2, E_DEC);
      step("r_exec", 4'd7, E_EXEC);
      step("r_rwb", 4'd8, E_RWB);
      step("r_fetch", 4'd1, E_FETCH);

      opcode = 6'd4;
      step("beq_dec", 4'd2, E_DEC);
      step("beq_beq", 4'd9, E_BEQ);
      step("beq_fetch", 4'd1, E_FETCH);

      opcode = 6'd2;
      step("j_dec", 4'd2, E_DEC);
      step("j_jmp", 4'd10, E_JMP);
      step("j_fetch", 4'd1, E_FETCH);

      opcode = 6'd8;
      step("addi_dec", 4'd2, E_DEC);
      step("addi_immex", 4'd11, E_IMMEX);
      step("addi_immwb", 4'd12, E_IMMWB);
      step("addi_fetch", 4'd1, E_FETCH);

      opcode = 6'd63;
      step("ill_dec", 4'd2, E_DECILL);
      step("ill_fetch", 4'd1, E_FETCH);

      opcode = 6'd12;
`ifdef ANDI_SUPPORT_EN
      step("andi_dec", 4'd2, E_DEC);
      step("andi_andiex", 4'd13, E_ANDIEX);
      step("andi_immwb", 4'd12, E_IMMWB);
      step("andi_fetch", 4'd1, E_FETCH);
`else
      step("andi_dec_ill", 4'd2, E_DECILL);
      step("andi_fetch", 4'd1, E_FETCH);
`endif

      // Asynchronous reset in the middle of a load
      opcode = 6'd35;
      step("rst_dec", 4'd2, E_DEC);
      step("rst_memadr", 4'd3, E_MEMADR);
      step("rst_memrd", 4'd4, E_MEMRD);
      #2 reset = 1'b1;
      #1 chk("async_reset", 4'd0, E_ZERO);
      @(negedge clk);
      reset = 1'b0;
      step("rst_refetch", 4'd1, E_FETCH);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
